ram_stream_reader: RTL and testbench

- Read-side sequencer for the single-port RAM (8-bit data, 6-bit address, 1-cycle registered read).
- On `start`, issues a burst of `len` sequential reads beginning at `base_addr`.
- Returns the read words as a valid/ready stream.
- Buffers read data in a small FIFO so the downstream consumer can stall without losing or duplicating words.

---
 rtl/ram_stream_reader.sv | 194 +++++++++++++++++++
 tb/tb_ram_stream_reader.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// Burst read sequencer for a 1-cycle registered-read RAM; delivers words as a valid/ready stream.
// Optional running checksum of delivered words is enabled by defining RAM_READER_CHECKSUM_EN.

// Generic small FIFO: registered storage, combinational head.
// Latency: push visible at head the cycle after the write edge.
// Backpressure: push is dropped only when full with no simultaneous pop (callers throttle upstream).
module ram_stream_reader_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop_ok;
    logic          push_ok;

    assign pop_ok  = pop && (count != '0);
    // A full FIFO can still accept a push when the head leaves in the same cycle.
    assign push_ok = push && ((count != CW'(DEPTH)) || pop_ok);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Issues len sequential RAM reads from base_addr and streams the returned words out.
// Latency: start edge E0 -> ram_addr=base after E1 -> first out_valid after E3.
// Backpressure: reads stop once in-flight reads plus buffered words reach FIFO_DEPTH.
module ram_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] checksum
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   remaining;
    logic                  s1_vld;     // address on the RAM bus this cycle
    logic                  s2_vld;     // ram_q holds that word this cycle
    logic [CW-1:0]         fifo_count;
    logic [CW:0]           occupancy;
    logic                  issue;
    logic                  xfer;

    assign ram_we    = 1'b0;
    assign out_valid = (fifo_count != '0);
    assign xfer      = out_valid && out_ready;

    // Every read in flight already owns a FIFO slot, so the FIFO can never overflow.
    assign occupancy = {1'b0, fifo_count} + (CW + 1)'(s1_vld) + (CW + 1)'(s2_vld);
    assign issue     = (state == FETCH) && (remaining != '0)
                       && (occupancy < (CW + 1)'(FIFO_DEPTH));

    ram_stream_reader_fifo #(
        .W     (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s2_vld),
        .wdata (ram_q),
        .pop   (xfer),
        .rdata (out_data),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            ram_addr  <= '0;
            rd_ptr    <= '0;
            remaining <= '0;
            s1_vld    <= 1'b0;
            s2_vld    <= 1'b0;
        end else begin
            s1_vld <= issue;
            s2_vld <= s1_vld;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rd_ptr    <= base_addr;
                        remaining <= len;
                        if (len != '0) begin
                            state <= FETCH;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (issue) begin
                        ram_addr  <= rd_ptr;
                        rd_ptr    <= rd_ptr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == (ADDR_WIDTH + 1)'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!s1_vld && !s2_vld && (fifo_count == '0)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef RAM_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else if ((state == IDLE) && start) begin
            sum <= '0;
        end else if (xfer) begin
            sum <= sum + out_data;
        end
    end

    assign checksum = sum;
`else
    assign checksum = '0;
`endif
endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a behavioural registered-read RAM.
module tb_ram_stream_reader;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [5:0] base_addr = '0;
    logic [6:0] len = '0;
    logic       busy, done, ram_we, out_valid;
    logic [5:0] ram_addr;
    logic [7:0] ram_q = '0;
    logic [7:0] out_data, checksum;
    logic       out_ready = 1'b1;

    logic [7:0] mem [64];

    int total = 0;
    int bad   = 0;

    logic [7:0] got_q [$];
    logic [5:0] addr_q [$];
    int         done_cnt, done_cyc, first_valid, we_seen, stall_max_addr, stall_data_bad;
    logic       busy_c1;
    logic [7:0] sum_at_done;

    ram_stream_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_q     (ram_q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_q <= mem[ram_addr];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_start(input logic [5:0] b, input logic [6:0] l);
        base_addr = b;
        len       = l;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Runs from just after the start edge; optionally stalls for stall_len cycles from the first
    // valid word and optionally pulses a second start at cycle poke_cyc.
    task automatic run_burst(input int max_cyc, input int stall_len, input int poke_cyc);
        got_q.delete();
        addr_q.delete();
        done_cnt = 0; done_cyc = -1; first_valid = -1; we_seen = 0;
        stall_max_addr = 0; stall_data_bad = 0; busy_c1 = 1'b0; sum_at_done = '0;
        out_ready = 1'b1;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 1) begin
                addr_q.push_back(ram_addr);
                busy_c1 = busy;
            end else if (ram_addr != addr_q[$]) begin
                addr_q.push_back(ram_addr);
            end
            if (ram_we) we_seen++;
            if (done) begin
                done_cnt++;
                done_cyc    = cyc;
                sum_at_done = checksum;
            end
            if (cyc == poke_cyc) begin
                base_addr = 6'd40;
                len       = 7'd5;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (stall_len > 0 && first_valid >= 0 && cyc < first_valid + stall_len) begin
                out_ready = 1'b0;
                if (out_data != 8'h01) stall_data_bad++;
                if (int'(ram_addr) > stall_max_addr) stall_max_addr = int'(ram_addr);
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (done_cnt > 0 && cyc >= done_cyc + 3) break;
        end
        start     = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        #3;
        total++;
        if ({busy, done, out_valid, ram_we} !== 4'b0000 || ram_addr !== 6'd0 || checksum !== 8'h00) begin
            bad++;
            $display("FAIL reset_state got busy=%b done=%b vld=%b we=%b addr=%0d sum=%0h want all 0",
                     busy, done, out_valid, ram_we, ram_addr, checksum);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_words(input string name, input logic [7:0] exp [$]);
        total++;
        if (got_q.size() != exp.size()) begin
            bad++;
            $display("FAIL %s_count got %0d want %0d", name, got_q.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                total++;
                if (got_q[i] !== exp[i]) begin
                    bad++;
                    $display("FAIL %s_word%0d got %02h want %02h", name, i, got_q[i], exp[i]);
                end
            end
        end
    endtask

    task automatic check_addrs(input string name, input logic [5:0] exp [$]);
        total++;
        if (addr_q.size() != exp.size()) begin
            bad++;
            $display("FAIL %s_addr_count got %0d want %0d", name, addr_q.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                total++;
                if (addr_q[i] !== exp[i]) begin
                    bad++;
                    $display("FAIL %s_addr%0d got %0d want %0d", name, i, addr_q[i], exp[i]);
                end
            end
        end
    endtask

    task automatic check_done(input string name);
        total++;
        if (done_cnt != 1) begin
            bad++;
            $display("FAIL %s_done_pulses got %0d want 1", name, done_cnt);
        end
        total++;
        if (we_seen != 0) begin
            bad++;
            $display("FAIL %s_ram_we got %0d high cycles want 0", name, we_seen);
        end
    endtask

    task automatic test_basic;
        logic [7:0] ew [$];
        logic [5:0] ea [$];
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
        do_start(6'd0, 7'd3);
        run_burst(60, 0, 0);
        ew = '{8'h01, 8'h02, 8'h03};
        ea = '{6'd0, 6'd1, 6'd2};
        check_words("basic", ew);
        check_addrs("basic", ea);
        check_done("basic");
        total++;
        if (first_valid != 3) begin
            bad++;
            $display("FAIL basic_first_valid got cycle %0d want 3", first_valid);
        end
        total++;
        if (busy_c1 !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_busy got during=%b after=%b want 1/0", busy_c1, busy);
        end
`ifdef RAM_READER_CHECKSUM_EN
        total++;
        if (sum_at_done !== 8'h06 || checksum !== 8'h06) begin
            bad++;
            $display("FAIL basic_checksum got done=%02h held=%02h want 06", sum_at_done, checksum);
        end
`else
        total++;
        if (sum_at_done !== 8'h00 || checksum !== 8'h00) begin
            bad++;
            $display("FAIL basic_checksum_off got %02h/%02h want 00", sum_at_done, checksum);
        end
`endif
    endtask

    task automatic test_backpressure;
        logic [7:0] ew [$];
        do_start(6'd0, 7'd3);
        run_burst(80, 5, 0);
        ew = '{8'h01, 8'h02, 8'h03};
        check_words("bp", ew);
        check_done("bp");
        total++;
        if (stall_data_bad != 0) begin
            bad++;
            $display("FAIL bp_held_data got %0d stalled cycles with data!=01 want 0", stall_data_bad);
        end
        total++;
        if (stall_max_addr > 1) begin
            bad++;
            $display("FAIL bp_addr_limit got ram_addr %0d want <=1", stall_max_addr);
        end
    endtask

    task automatic test_start_while_busy;
        logic [7:0] ew [$];
        logic [5:0] ea [$];
        do_start(6'd0, 7'd3);
        run_burst(60, 0, 1);
        ew = '{8'h01, 8'h02, 8'h03};
        ea = '{6'd0, 6'd1, 6'd2};
        check_words("busy_start", ew);
        check_addrs("busy_start", ea);
        check_done("busy_start");
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL busy_start_idle got busy=%b vld=%b want 0/0", busy, out_valid);
        end
    endtask

    task automatic test_wrap;
        logic [7:0] ew [$];
        logic [5:0] ea [$];
        mem[62] = 8'hAA; mem[63] = 8'hBB;
        do_start(6'd62, 7'd4);
        run_burst(60, 0, 0);
        ew = '{8'hAA, 8'hBB, 8'h01, 8'h02};
        ea = '{6'd62, 6'd63, 6'd0, 6'd1};
        check_words("wrap", ew);
        check_addrs("wrap", ea);
        check_done("wrap");
    endtask

    task automatic test_len_zero;
        logic [5:0] addr_before;
        int         vld_seen;
        addr_before = ram_addr;
        do_start(6'd7, 7'd0);
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL len0_done got done=%b busy=%b vld=%b want 1/0/0", done, busy, out_valid);
        end
        vld_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (out_valid || done) vld_seen++;
        end
        total++;
        if (vld_seen != 0 || ram_addr !== addr_before) begin
            bad++;
            $display("FAIL len0_quiet got %0d busy cycles addr=%0d want 0 and addr=%0d",
                     vld_seen, ram_addr, addr_before);
        end
    endtask

    task automatic test_checksum_wrap;
        logic [7:0] ew [$];
        mem[10] = 8'hFF; mem[11] = 8'h02;
        do_start(6'd10, 7'd2);
        run_burst(60, 0, 0);
        ew = '{8'hFF, 8'h02};
        check_words("cks", ew);
        check_done("cks");
`ifdef RAM_READER_CHECKSUM_EN
        total++;
        if (sum_at_done !== 8'h01 || checksum !== 8'h01) begin
            bad++;
            $display("FAIL cks_value got done=%02h held=%02h want 01", sum_at_done, checksum);
        end
`else
        total++;
        if (sum_at_done !== 8'h00 || checksum !== 8'h00) begin
            bad++;
            $display("FAIL cks_off got %02h/%02h want 00", sum_at_done, checksum);
        end
`endif
    endtask

    task automatic test_len_max;
        logic [7:0] ew [$];
        logic [5:0] ea [$];
        for (int i = 0; i < 64; i++) mem[i] = 8'(i * 3 + 7);
        for (int k = 0; k < 64; k++) begin
            ew.push_back(mem[(20 + k) % 64]);
            ea.push_back(6'((20 + k) % 64));
        end
        do_start(6'd20, 7'd64);
        run_burst(400, 0, 0);
        check_words("len64", ew);
        check_addrs("len64", ea);
        check_done("len64");
    endtask

    task automatic test_reset_mid_burst;
        int seen, late;
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
        do_start(6'd0, 7'd3);
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            if (out_valid && out_ready) seen = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        total++;
        if (seen == 0) begin
            bad++;
            $display("FAIL rst_mid_first_word got none in 20 cycles want one");
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        total++;
        if ({busy, done, out_valid, ram_we} !== 4'b0000 || ram_addr !== 6'd0 || checksum !== 8'h00) begin
            bad++;
            $display("FAIL rst_mid_state got busy=%b done=%b vld=%b we=%b addr=%0d sum=%0h want all 0",
                     busy, done, out_valid, ram_we, ram_addr, checksum);
        end
        @(posedge clk);
        #1;
        rst  = 1'b0;
        late = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid || done || busy) late++;
        end
        total++;
        if (late != 0) begin
            bad++;
            $display("FAIL rst_mid_quiet got %0d active cycles want 0", late);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        test_reset();
        test_basic();
        test_backpressure();
        test_start_while_busy();
        test_wrap();
        test_len_zero();
        test_checksum_wrap();
        test_len_max();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
